// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_pkg
// Brief  : Shared constants, types and helpers for the bus device endpoint.
// Rev    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    // Widest packet get_dest() can take; narrower packets are zero-extended.
    localparam int MAX_PKT_W = 64;

    localparam int ERR_CNT_W = 8;
    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int                   pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module : fifo_fwft
// Brief  : First-word fall-through FIFO; occupancy counter separates full/empty.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_fwft #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [width-1:0]         wr_data,
    input  logic                     rd,
    output logic [width-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count
);

    localparam int PTR_W = $clog2(depth);
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(depth);

    logic [width-1:0] r_mem [depth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_rd_en;
    logic w_wr_en;

    // A read frees a slot on the same edge, so a full FIFO can still take a write.
    assign w_rd_en = rd && (r_count != '0);
    assign w_wr_en = wr && ((r_count != c_depth) || w_rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);
    assign full    = (r_count == c_depth);
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/bus_dev_port.sv
`default_nettype none
// ============================================================================
// Module : bus_dev_port
// Brief  : Bus device endpoint: TX/RX FIFOs, RX destination filter, error counters.
// Rev    : 1.0 - initial release
// ============================================================================
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int              width     = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'h00,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
    parameter int              cnt_w     = $bits(err_cnt_t)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     pndng,
    output logic [width-1:0]         D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [width-1:0]         D_push,
    input  logic                     tx_wr,
    input  logic [width-1:0]         tx_data,
    output logic                     tx_full,
    input  logic                     rx_rd,
    output logic [width-1:0]         rx_data,
    output logic                     rx_valid,
    output logic [$clog2(depth):0]   tx_count,
    output logic [$clog2(depth):0]   rx_count,
    output logic [cnt_w-1:0]         ovf_cnt,
    output logic [cnt_w-1:0]         misroute_cnt
);

    localparam logic [cnt_w-1:0] c_sat_max = '1;

    logic            w_tx_empty;
    logic            w_rx_empty;
    logic            w_rx_full;
    logic [ID_W-1:0] w_dest;
    logic            w_dest_ok;
    logic            w_misroute;
    logic            w_ovf;
    logic            w_store;
    logic [cnt_w-1:0] r_ovf_cnt;
    logic [cnt_w-1:0] r_misroute_cnt;

    fifo_fwft #(
        .width (width),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (D_pop),
        .empty   (w_tx_empty),
        .full    (tx_full),
        .count   (tx_count)
    );

    // Misroute takes priority, so a wrong-destination packet never counts as overflow.
    assign w_dest     = get_dest(MAX_PKT_W'(D_push), width);
    assign w_dest_ok  = (w_dest == id) || (w_dest == broadcast);
    assign w_misroute = push && !w_dest_ok;
    assign w_ovf      = push && w_dest_ok && w_rx_full && !rx_rd;
    assign w_store    = push && w_dest_ok && (!w_rx_full || rx_rd);

    fifo_fwft #(
        .width (width),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (w_store),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (rx_data),
        .empty   (w_rx_empty),
        .full    (w_rx_full),
        .count   (rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_cnt      <= '0;
            r_misroute_cnt <= '0;
        end else begin
            if (w_ovf && (r_ovf_cnt != c_sat_max)) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
            if (w_misroute && (r_misroute_cnt != c_sat_max)) begin
                r_misroute_cnt <= r_misroute_cnt + 1'b1;
            end
        end
    end

    assign pndng        = !w_tx_empty;
    assign rx_valid     = !w_rx_empty;
    assign ovf_cnt      = r_ovf_cnt;
    assign misroute_cnt = r_misroute_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_dev_port.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_dev_port
// Brief  : Queue-based reference model with per-cycle compare, directed + random stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bus_dev_port;

    localparam int         WIDTH = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'h02;

    logic              clk = 1'b0;
    logic              reset;
    logic              pndng;
    logic [WIDTH-1:0]  D_pop;
    logic              pop;
    logic              push;
    logic [WIDTH-1:0]  D_push;
    logic              tx_wr;
    logic [WIDTH-1:0]  tx_data;
    logic              tx_full;
    logic              rx_rd;
    logic [WIDTH-1:0]  rx_data;
    logic              rx_valid;
    logic [3:0]        tx_count;
    logic [3:0]        rx_count;
    logic [7:0]        ovf_cnt;
    logic [7:0]        misroute_cnt;

    bus_dev_port #(
        .width (WIDTH),
        .depth (DEPTH),
        .id    (ID)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .ovf_cnt      (ovf_cnt),
        .misroute_cnt (misroute_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain queues and counters updated on every edge.
    logic [WIDTH-1:0] m_tx[$];
    logic [WIDTH-1:0] m_rx[$];
    int               m_ovf = 0;
    int               m_mis = 0;

    always @(posedge clk) begin : model
        bit pop_ok, wr_ok, rd_ok;
        logic [7:0] dest;
        if (reset) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 0;
            m_mis = 0;
        end else begin
            pop_ok = pop && (m_tx.size() > 0);
            wr_ok  = tx_wr && ((m_tx.size() < DEPTH) || pop_ok);
            if (pop_ok) void'(m_tx.pop_front());
            if (wr_ok)  m_tx.push_back(tx_data);

            rd_ok = rx_rd && (m_rx.size() > 0);
            if (rd_ok) void'(m_rx.pop_front());
            if (push) begin
                dest = D_push[15:8];
                if (dest != ID && dest != 8'hFF) begin
                    if (m_mis < 255) m_mis++;
                end else if ((m_rx.size() + (rd_ok ? 1 : 0)) == DEPTH && !rx_rd) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    m_rx.push_back(D_push);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (check_en) begin
            chk("pndng",    32'(pndng),    32'(m_tx.size() != 0));
            chk("D_pop",    32'(D_pop),    (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'd0);
            chk("tx_full",  32'(tx_full),  32'(m_tx.size() == DEPTH));
            chk("tx_count", 32'(tx_count), 32'(m_tx.size()));
            chk("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
            chk("rx_data",  32'(rx_data),  (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
            chk("rx_count", 32'(rx_count), 32'(m_rx.size()));
            chk("ovf_cnt",  32'(ovf_cnt),  32'(m_ovf));
            chk("mis_cnt",  32'(misroute_cnt), 32'(m_mis));
        end
    end

    task automatic idle();
        reset = 1'b0; pop = 1'b0; push = 1'b0; D_push = '0;
        tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_pndng",    32'(pndng), 32'd0);
        chk("rst_D_pop",    32'(D_pop), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_ovf",      32'(ovf_cnt), 32'd0);
        idle();

        // Single TX write then pop
        tx_wr = 1'b1; tx_data = 16'h02AB; tick();
        chk("t1_pndng", 32'(pndng), 32'd1);
        chk("t1_D_pop", 32'(D_pop), 32'h02AB);
        idle(); tick();
        pop = 1'b1; tick();
        chk("t1_pndng_after_pop", 32'(pndng), 32'd0);
        chk("t1_D_pop_after_pop", 32'(D_pop), 32'd0);
        idle();

        // Fill TX, 9th write dropped, drain in order
        for (int i = 0; i < 9; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0100 + 16'(i); tick();
        end
        idle();
        chk("t2_tx_full",  32'(tx_full), 32'd1);
        chk("t2_tx_count", 32'(tx_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_D_pop_seq", 32'(D_pop), 32'h0100 + 32'(i));
            pop = 1'b1; tick();
        end
        idle();
        chk("t2_pndng_empty", 32'(pndng), 32'd0);

        // RX filtering
        push = 1'b1; D_push = 16'h0255; tick();
        D_push = 16'hFF11; tick();
        D_push = 16'h0377; tick();
        idle();
        chk("t3_rx_count", 32'(rx_count), 32'd2);
        chk("t3_rx_data0", 32'(rx_data), 32'h0255);
        chk("t3_mis",      32'(misroute_cnt), 32'd1);
        rx_rd = 1'b1; tick();
        chk("t3_rx_data1", 32'(rx_data), 32'hFF11);
        tick();
        idle();
        chk("t3_rx_empty", 32'(rx_valid), 32'd0);

        // RX overflow
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i); tick();
        end
        idle();
        chk("t4_ovf",      32'(ovf_cnt), 32'd2);
        chk("t4_rx_count", 32'(rx_count), 32'd8);
        push = 1'b1; D_push = 16'h0299; rx_rd = 1'b1; tick();
        idle();
        chk("t4_ovf_hold", 32'(ovf_cnt), 32'd2);
        chk("t4_rx_count2", 32'(rx_count), 32'd8);
        chk("t4_rx_head",  32'(rx_data), 32'h0201);
        rx_rd = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        idle();

        // TX full with simultaneous write and pop
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0300 + 16'(i); tick();
        end
        tx_wr = 1'b1; tx_data = 16'h03AA; pop = 1'b1; tick();
        idle();
        chk("t5_tx_count", 32'(tx_count), 32'd8);
        chk("t5_head",     32'(D_pop), 32'h0301);
        pop = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        idle();
        chk("t5_tail", 32'(D_pop), 32'h03AA);
        chk("t5_tx_count1", 32'(tx_count), 32'd1);
        pop = 1'b1; tick();

        // RX empty with push and rx_rd together
        idle();
        push = 1'b1; D_push = 16'h02CC; rx_rd = 1'b1; tick();
        idle();
        chk("t5_rx_count", 32'(rx_count), 32'd1);
        chk("t5_rx_data",  32'(rx_data), 32'h02CC);
        rx_rd = 1'b1; tick();
        idle();

        // Reset mid-traffic
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0400 + 16'(i);
            push = (i < 3) || (i == 4);
            D_push = (i == 4) ? 16'h0701 : 16'h02E0 + 16'(i);
            tick();
        end
        idle();
        chk("t6_tx_count", 32'(tx_count), 32'd5);
        chk("t6_rx_count", 32'(rx_count), 32'd3);
        reset = 1'b1; pop = 1'b1; push = 1'b1; D_push = 16'h02F0; tx_wr = 1'b1; tx_data = 16'h04FF;
        tick();
        idle();
        chk("t6_pndng",   32'(pndng), 32'd0);
        chk("t6_D_pop",   32'(D_pop), 32'd0);
        chk("t6_rx_valid",32'(rx_valid), 32'd0);
        chk("t6_rx_data", 32'(rx_data), 32'd0);
        chk("t6_mis",     32'(misroute_cnt), 32'd0);

        // Misroute saturation
        push = 1'b1; D_push = 16'h0555;
        for (int i = 0; i < 300; i++) tick();
        idle();
        chk("t7_mis_sat", 32'(misroute_cnt), 32'd255);

        // Randomized traffic
        reset = 1'b1; tick();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            reset = ($urandom_range(0, 299) == 0);
            pop   = ($urandom_range(0, 2) == 0);
            tx_wr = ($urandom_range(0, 1) == 0);
            tx_data = 16'($urandom);
            rx_rd = ($urandom_range(0, 3) == 0);
            push  = ($urandom_range(0, 1) == 0);
            sel = $urandom_range(0, 3);
            D_push[7:0]  = 8'($urandom);
            D_push[15:8] = (sel == 0) ? 8'hFF : (sel == 3) ? 8'($urandom) : ID;
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
